// File: rtl/nv_pg_sleep_seq.sv
// Power-gating sequencer: staggered bank switch-on, then isolation release.
// Power-down reverses the order; every output comes straight from a flop.
module nv_pg_sleep_seq #(
  parameter int NBANK   = 4,
  parameter int STAGGER = 8
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             pwr_req,
  output logic             pwr_ack,
  output logic [NBANK-1:0] pg_en,
  output logic             iso_n,
  output logic             busy
);

  localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int IW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STAGGER - 1);
  localparam logic [IW-1:0] LAST   = IW'(NBANK - 1);

  typedef enum logic [2:0] {
    OFF,
    UP_SEQ,
    UP_ISO,
    ON,
    DN_SEQ
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_d;
  logic [NBANK-1:0] pg_d;
  logic             ack_d;
  logic             iso_d;
  logic             busy_d;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state   <= OFF;
      cnt     <= '0;
      idx     <= '0;
      pg_en   <= '0;
      iso_n   <= 1'b0;
      pwr_ack <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
      pg_en   <= pg_d;
      iso_n   <= iso_d;
      pwr_ack <= ack_d;
      busy    <= busy_d;
    end
  end

  // Once bank 0 is cleared, spend one more cycle in DN_SEQ before the ack drops.
  always_comb begin
    state_d = state;
    unique case (state)
      OFF:     if (pwr_req) state_d = UP_SEQ;
      UP_SEQ:  if (cnt == '0 && idx == LAST) state_d = UP_ISO;
      UP_ISO:  state_d = ON;
      ON:      if (!pwr_req) state_d = DN_SEQ;
      DN_SEQ:  if (!pg_en[0]) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    cnt_d  = cnt;
    idx_d  = idx;
    pg_d   = pg_en;
    iso_d  = iso_n;
    ack_d  = pwr_ack;
    busy_d = state_d inside {UP_SEQ, UP_ISO, DN_SEQ};
    unique case (state)
      OFF: begin
        if (pwr_req) begin
          pg_d[0] = 1'b1;
          idx_d   = '0;
          cnt_d   = RELOAD;
        end
      end
      UP_SEQ: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else if (idx < LAST) begin
          idx_d       = idx + 1'b1;
          pg_d[idx_d] = 1'b1;
          cnt_d       = RELOAD;
        end else begin
          iso_d = 1'b1;
        end
      end
      UP_ISO: ack_d = 1'b1;
      ON: begin
        if (!pwr_req) begin
          iso_d = 1'b0;
          idx_d = LAST;
          cnt_d = RELOAD;
        end
      end
      DN_SEQ: begin
        if (!pg_en[0]) begin
          ack_d = 1'b0;
        end else if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          pg_d[idx] = 1'b0;
          cnt_d     = RELOAD;
          if (idx != '0) idx_d = idx - 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nv_pg_sleep_seq.sv
// Bench for nv_pg_sleep_seq: a 4x8 and a 1x1 instance share clock, reset
// and request; a timing-formula model is compared on every falling edge.
module tb_nv_pg_sleep_seq;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req = 1'b0;
  logic       ack4;
  logic       iso4;
  logic       busy4;
  logic [3:0] pg4;
  logic       ack1;
  logic       iso1;
  logic       busy1;
  logic [0:0] pg1;

  int checks = 0;
  int errors = 0;

  // model phase: 0 off, 1 powering up, 2 on, 3 powering down
  int md[2] = '{0, 0};
  int e[2]  = '{0, 0};

  always #5 clk = ~clk;

  nv_pg_sleep_seq #(.NBANK(4), .STAGGER(8)) dut4 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .pwr_req         (req),
    .pwr_ack         (ack4),
    .pg_en           (pg4),
    .iso_n           (iso4),
    .busy            (busy4)
  );

  nv_pg_sleep_seq #(.NBANK(1), .STAGGER(1)) dut1 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .pwr_req         (req),
    .pwr_ack         (ack1),
    .pg_en           (pg1),
    .iso_n           (iso1),
    .busy            (busy1)
  );

  function automatic int nb(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int st(int i);
    return (i == 0) ? 8 : 1;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Outputs as a function of phase and cycles elapsed since the trigger edge.
  task automatic model_out(input int n, input int s, input int m, input int el,
                           output logic [15:0] pg, output logic iso,
                           output logic ack, output logic bsy);
    int c;
    c   = 0;
    iso = 1'b0;
    ack = 1'b0;
    bsy = 1'b0;
    case (m)
      1: begin
        c   = (el / s + 1 < n) ? el / s + 1 : n;
        iso = (el >= n * s);
        bsy = 1'b1;
      end
      2: begin
        c   = n;
        iso = 1'b1;
        ack = 1'b1;
      end
      3: begin
        c   = n - ((el / s < n) ? el / s : n);
        ack = 1'b1;
        bsy = 1'b1;
      end
      default: c = 0;
    endcase
    pg = 16'((32'd1 << c) - 1);
  endtask

  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        md[i] <= 0;
        e[i]  <= 0;
      end else begin
        case (md[i])
          0: if (req) begin md[i] <= 1; e[i] <= 0; end
          1: if (e[i] == nb(i) * st(i)) md[i] <= 2; else e[i] <= e[i] + 1;
          2: if (!req) begin md[i] <= 3; e[i] <= 0; end
          default: if (e[i] == nb(i) * st(i)) md[i] <= 0; else e[i] <= e[i] + 1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] p;
    logic        iso;
    logic        ack;
    logic        bsy;
    for (int i = 0; i < 2; i++) begin
      model_out(nb(i), st(i), md[i], e[i], p, iso, ack, bsy);
      chk($sformatf("d%0d pg_en", i), (i == 0) ? 16'(pg4) : 16'(pg1), p);
      chk($sformatf("d%0d iso_n", i), 16'((i == 0) ? iso4 : iso1), 16'(iso));
      chk($sformatf("d%0d pwr_ack", i), 16'((i == 0) ? ack4 : ack1), 16'(ack));
      chk($sformatf("d%0d busy", i), 16'((i == 0) ? busy4 : busy1), 16'(bsy));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(string tag);
    chk({tag, " pg4"}, 16'(pg4), 16'h0);
    chk({tag, " iso4"}, 16'(iso4), 16'h0);
    chk({tag, " ack4"}, 16'(ack4), 16'h0);
    chk({tag, " busy4"}, 16'(busy4), 16'h0);
    chk({tag, " pg1"}, 16'(pg1), 16'h0);
  endtask

  initial begin
    repeat (3) tick;
    all_zero("reset");
    rstn = 1'b1;
    repeat (20) tick;
    all_zero("idle");

    req = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      tick;
      case (k)
        0: begin
          chk("up pg@0", 16'(pg4), 16'h1);
          chk("up busy@0", 16'(busy4), 16'h1);
          chk("s up pg@0", 16'(pg1), 16'h1);
          chk("s up iso@0", 16'(iso1), 16'h0);
        end
        1: chk("s up iso@1", 16'(iso1), 16'h1);
        2: chk("s up ack@2", 16'(ack1), 16'h1);
        8: chk("up pg@8", 16'(pg4), 16'h3);
        16: chk("up pg@16", 16'(pg4), 16'h7);
        24: begin
          chk("up pg@24", 16'(pg4), 16'hf);
          chk("up iso@24", 16'(iso4), 16'h0);
        end
        32: begin
          chk("up iso@32", 16'(iso4), 16'h1);
          chk("up ack@32", 16'(ack4), 16'h0);
        end
        33: begin
          chk("up ack@33", 16'(ack4), 16'h1);
          chk("up busy@33", 16'(busy4), 16'h0);
        end
        default: ;
      endcase
    end

    req = 1'b0;
    for (int k = 0; k <= 35; k++) begin
      tick;
      case (k)
        0: begin
          chk("dn iso@0", 16'(iso4), 16'h0);
          chk("dn pg@0", 16'(pg4), 16'hf);
          chk("s dn iso@0", 16'(iso1), 16'h0);
        end
        1: chk("s dn pg@1", 16'(pg1), 16'h0);
        2: chk("s dn ack@2", 16'(ack1), 16'h0);
        8: chk("dn pg@8", 16'(pg4), 16'h7);
        16: chk("dn pg@16", 16'(pg4), 16'h3);
        24: chk("dn pg@24", 16'(pg4), 16'h1);
        32: begin
          chk("dn pg@32", 16'(pg4), 16'h0);
          chk("dn ack@32", 16'(ack4), 16'h1);
        end
        33: chk("dn ack@33", 16'(ack4), 16'h0);
        default: ;
      endcase
    end

    req = 1'b1;
    for (int k = 0; k <= 70; k++) begin
      tick;
      if (k == 5) req = 1'b0;
      case (k)
        33: chk("pulse ack@33", 16'(ack4), 16'h1);
        34: chk("pulse iso@34", 16'(iso4), 16'h0);
        66: chk("pulse ack@66", 16'(ack4), 16'h1);
        67: chk("pulse ack@67", 16'(ack4), 16'h0);
        default: ;
      endcase
    end

    req = 1'b1;
    for (int k = 0; k <= 17; k++) tick;
    #2;
    rstn = 1'b0;
    #1;
    all_zero("async rst");
    tick;
    tick;
    rstn = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick;
      if (k == 0) chk("restart pg@0", 16'(pg4), 16'h1);
      if (k == 7) chk("restart pg@7", 16'(pg4), 16'h1);
      if (k == 8) chk("restart pg@8", 16'(pg4), 16'h3);
    end

    for (int k = 0; k < 1500; k++) begin
      int r;
      tick;
      r = int'($urandom_range(0, 199));
      if (r < 12) req = ~req;
      if (r == 199) begin
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
      end
    end

    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
